// File: rtl/iterative_multiplier.sv
// Multi-cycle unsigned MUL/MLA: streams one nibble pair per cycle through a 4x4
// multiplier and accumulates shifted partial products into a 2*WIDTH-bit result.

module iterative_multiplier_mul4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (b[r]) begin
        p = p + (8'(a) << r);
      end
    end
  end

endmodule

module iterative_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned STEPS = N * N;
  localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [KW-1:0]        idx_i, idx_j;
  logic [KW:0]          sh_nib;
  logic [3:0]           nib_a, nib_b;
  logic [7:0]           pp;
  logic [2*WIDTH-1:0]   pp_shifted;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_step;

  iterative_multiplier_mul4x4 u_mul4x4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  // Step k walks a's nibbles fastest: i = k mod N, j = k div N.
  always_comb begin
    idx_i      = KW'(32'(k_q) % N);
    idx_j      = KW'(32'(k_q) / N);
    sh_nib     = {1'b0, idx_i} + {1'b0, idx_j};
    nib_a      = 4'(a_q >> {idx_i, 2'b00});
    nib_b      = 4'(b_q >> {idx_j, 2'b00});
    pp_shifted = {{(2*WIDTH-8){1'b0}}, pp} << {sh_nib, 2'b00};
    acc_sum    = acc_q + pp_shifted;
    last_step  = (k_q == KW'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          k_d     = '0;
          a_d     = a;
          b_d     = b;
          acc_d   = acc_en ? {{WIDTH{1'b0}}, c} : '0;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (last_step) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    product   = acc_q;
  end

endmodule
